// File: rtl/unidade_controle_rodadas_pkg.sv
// State codes shared by the round-based game controller and anything that decodes db_estado.
// The codes are the values shown on the hexa7seg debug display.
package unidade_controle_rodadas_pkg;

    localparam int ESTADO_W = 4;

    typedef enum logic [ESTADO_W-1:0] {
        INICIAL       = 4'h0,
        PREPARACAO    = 4'h1,
        INICIA_RODADA = 4'h2,
        ESPERA_JOGADA = 4'h3,
        REGISTRA      = 4'h4,
        COMPARACAO    = 4'h5,
        PROX_JOGADA   = 4'h6,
        PROX_RODADA   = 4'h7,
        FIM_ACERTOU   = 4'hA,
        FIM_TIMEOUT   = 4'hD,
        FIM_ERROU     = 4'hE
    } estado_t;

    // End states wait for iniciar and hold the game verdict on the outputs.
    function automatic logic eh_estado_final(input estado_t e);
        return (e == FIM_ACERTOU) || (e == FIM_ERROU) || (e == FIM_TIMEOUT);
    endfunction

endpackage

// File: rtl/unidade_controle_rodadas.sv
// Moore FSM sequencing the round-based memory game: round N replays positions 0..N, and the
// game ends on a wrong key, a timeout, or after the final round.
module unidade_controle_rodadas
    import unidade_controle_rodadas_pkg::*;
#(
    parameter bit ENABLE_TIMEOUT = 1'b1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                iniciar,
    input  logic                jogada,
    input  logic                igual,
    input  logic                enderecoIgualLimite,
    input  logic                fimL,
    input  logic                fimT,
    output logic                zeraE,
    output logic                contaE,
    output logic                zeraL,
    output logic                contaL,
    output logic                zeraR,
    output logic                registraR,
    output logic                zeraT,
    output logic                contaT,
    output logic                pronto,
    output logic                acertou,
    output logic                errou,
    output logic                errou_timeout,
    output logic [ESTADO_W-1:0] db_estado
);

    estado_t estado;
    estado_t proximo;
    logic    timeout_ativo;

    assign timeout_ativo = ENABLE_TIMEOUT & fimT;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado <= INICIAL;
        end else begin
            estado <= proximo;
        end
    end

    // A key press beats a coincident timeout; unused codes fall back to INICIAL.
    always_comb begin
        proximo = INICIAL;
        case (estado)
            INICIAL:       proximo = iniciar ? PREPARACAO : INICIAL;
            PREPARACAO:    proximo = INICIA_RODADA;
            INICIA_RODADA: proximo = ESPERA_JOGADA;
            ESPERA_JOGADA: begin
                if (jogada) begin
                    proximo = REGISTRA;
                end else if (timeout_ativo) begin
                    proximo = FIM_TIMEOUT;
                end else begin
                    proximo = ESPERA_JOGADA;
                end
            end
            REGISTRA:      proximo = COMPARACAO;
            COMPARACAO: begin
                if (!igual) begin
                    proximo = FIM_ERROU;
                end else if (!enderecoIgualLimite) begin
                    proximo = PROX_JOGADA;
                end else if (!fimL) begin
                    proximo = PROX_RODADA;
                end else begin
                    proximo = FIM_ACERTOU;
                end
            end
            PROX_JOGADA:   proximo = ESPERA_JOGADA;
            PROX_RODADA:   proximo = INICIA_RODADA;
            FIM_ACERTOU,
            FIM_ERROU,
            FIM_TIMEOUT:   proximo = iniciar ? PREPARACAO : estado;
            default:       proximo = INICIAL;
        endcase
    end

    always_comb begin
        zeraE         = 1'b0;
        contaE        = 1'b0;
        zeraL         = 1'b0;
        contaL        = 1'b0;
        zeraR         = 1'b0;
        registraR     = 1'b0;
        zeraT         = 1'b0;
        contaT        = 1'b0;
        pronto        = 1'b0;
        acertou       = 1'b0;
        errou         = 1'b0;
        errou_timeout = 1'b0;
        case (estado)
            PREPARACAO: begin
                zeraE = 1'b1;
                zeraL = 1'b1;
                zeraR = 1'b1;
                zeraT = 1'b1;
            end
            INICIA_RODADA: begin
                zeraE = 1'b1;
                zeraT = 1'b1;
            end
            ESPERA_JOGADA: contaT = ENABLE_TIMEOUT;
            REGISTRA: begin
                registraR = 1'b1;
                zeraT     = 1'b1;
            end
            PROX_JOGADA:   contaE = 1'b1;
            PROX_RODADA:   contaL = 1'b1;
            FIM_ACERTOU: begin
                pronto  = 1'b1;
                acertou = 1'b1;
            end
            FIM_ERROU: begin
                pronto = 1'b1;
                errou  = 1'b1;
            end
            FIM_TIMEOUT: begin
                pronto        = 1'b1;
                errou         = 1'b1;
                errou_timeout = 1'b1;
            end
            default: ;
        endcase
    end

    assign db_estado = estado;

endmodule
